// File: rtl/lorenz_step_scheduler.sv
// Lorenz Euler-step scheduler: a single shared Q7.20 multiplier is stepped
// through eight product phases, then one update cycle commits X/Y/Z.
module lorenz_step_scheduler #(
  parameter int unsigned W    = 27,
  parameter int unsigned FRAC = 20,
  parameter int unsigned CW   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CW-1:0]       n_steps,
  input  logic                halt,
  input  logic                reload,
  input  logic signed [W-1:0] dt,
  input  logic signed [W-1:0] sigma,
  input  logic signed [W-1:0] beta,
  input  logic signed [W-1:0] rho,
  input  logic signed [W-1:0] X0,
  input  logic signed [W-1:0] Y0,
  input  logic signed [W-1:0] Z0,
  output logic                busy,
  output logic                step_valid,
  output logic                done,
  output logic [CW-1:0]       step_idx,
  output logic signed [W-1:0] X_K,
  output logic signed [W-1:0] Y_K,
  output logic signed [W-1:0] Z_K
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned KW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_UPD
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   phase_q, phase_d;

  logic            accept, load_init, commit;
  logic            busy_d, sv_d, done_d;
  logic [CW-1:0]   idx_next;
  logic [CW-1:0]   n_lat;

  logic signed [W-1:0]  dt_l, sigma_l, beta_l, rho_l;
  logic signed [W-1:0]  m [8];
  logic signed [W-1:0]  op_a, op_b, mul_res;
  logic signed [PW-1:0] prod;

  assign idx_next = step_idx + CW'(1);

  // State and phase register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    accept    = 1'b0;
    load_init = 1'b0;
    commit    = 1'b0;
    busy_d    = busy;
    sv_d      = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (reload) begin
          load_init = 1'b1;
        end else if (start) begin
          if (n_steps == '0) begin
            done_d = 1'b1;
          end else begin
            accept  = 1'b1;
            busy_d  = 1'b1;
            state_d = S_MUL;
            phase_d = '0;
          end
        end
      end
      S_MUL: begin
        if (halt) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          phase_d = '0;
        end else begin
          if (phase_q == KW'(7)) state_d = S_UPD;
          phase_d = phase_q + KW'(1);
        end
      end
      S_UPD: begin
        commit  = 1'b1;
        sv_d    = 1'b1;
        phase_d = '0;
        if (halt) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (idx_next == n_lat) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_MUL;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Operand select for the shared multiplier, one product per phase
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (phase_q)
      3'd0: begin op_a = Y_K - X_K; op_b = dt_l;        end
      3'd1: begin op_a = m[0];      op_b = sigma_l;     end
      3'd2: begin op_a = X_K;       op_b = dt_l;        end
      3'd3: begin op_a = m[2];      op_b = rho_l - Z_K; end
      3'd4: begin op_a = Y_K;       op_b = dt_l;        end
      3'd5: begin op_a = m[2];      op_b = Y_K;         end
      3'd6: begin op_a = Z_K;       op_b = dt_l;        end
      3'd7: begin op_a = m[6];      op_b = beta_l;      end
      default: begin op_a = '0;     op_b = '0;          end
    endcase
  end

  // Full-width signed product; arithmetic shift floors, truncation wraps
  assign prod    = PW'(op_a) * PW'(op_b);
  assign mul_res = W'(prod >>> FRAC);

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      X_K        <= X0;
      Y_K        <= Y0;
      Z_K        <= Z0;
      busy       <= 1'b0;
      step_valid <= 1'b0;
      done       <= 1'b0;
      step_idx   <= '0;
      n_lat      <= '0;
      dt_l       <= '0;
      sigma_l    <= '0;
      beta_l     <= '0;
      rho_l      <= '0;
      for (int i = 0; i < 8; i++) m[i] <= '0;
    end else begin
      busy       <= busy_d;
      step_valid <= sv_d;
      done       <= done_d;
      if (load_init) begin
        X_K <= X0;
        Y_K <= Y0;
        Z_K <= Z0;
      end
      if (accept) begin
        n_lat    <= n_steps;
        dt_l     <= dt;
        sigma_l  <= sigma;
        beta_l   <= beta;
        rho_l    <= rho;
        step_idx <= '0;
      end
      if (state_q == S_MUL) m[phase_q] <= mul_res;
      if (commit) begin
        X_K      <= X_K + m[1];
        Y_K      <= Y_K + m[3] - m[4];
        Z_K      <= Z_K + m[5] - m[7];
        step_idx <= idx_next;
      end
    end
  end

endmodule

// File: tb/tb_lorenz_step_scheduler.sv
// Bench for lorenz_step_scheduler: step-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized runs.
module tb_lorenz_step_scheduler;

  localparam int unsigned W    = 27;
  localparam int unsigned FRAC = 20;
  localparam int unsigned CW   = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [CW-1:0]       n_steps = '0;
  logic                halt = 1'b0;
  logic                reload = 1'b0;
  logic signed [W-1:0] dt, sigma, beta, rho, X0, Y0, Z0;
  logic                busy, step_valid, done;
  logic [CW-1:0]       step_idx;
  logic signed [W-1:0] X_K, Y_K, Z_K;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;

  lorenz_step_scheduler #(.W(W), .FRAC(FRAC), .CW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .n_steps(n_steps),
    .halt(halt), .reload(reload),
    .dt(dt), .sigma(sigma), .beta(beta), .rho(rho),
    .X0(X0), .Y0(Y0), .Z0(Z0),
    .busy(busy), .step_valid(step_valid), .done(done), .step_idx(step_idx),
    .X_K(X_K), .Y_K(Y_K), .Z_K(Z_K)
  );

  always #5 clk = ~clk;

  // Reference model state: one Euler step is computed whole, on the ninth
  // busy edge after the run was accepted.
  bit                  md_busy = 0, md_sv = 0, md_done = 0;
  int                  md_phase = 0, md_n = 0, md_idx = 0;
  logic signed [W-1:0] mx = '0, my = '0, mz = '0;
  logic signed [W-1:0] c_dt = '0, c_sigma = '0, c_beta = '0, c_rho = '0;

  function automatic logic signed [W-1:0] fmul(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return W'(p >>> FRAC);
  endfunction

  function automatic logic signed [W-1:0] rnd(input int span);
    int v;
    v = int'($urandom_range(2 * span, 0)) - span;
    return W'(v);
  endfunction

  task automatic model_step();
    logic signed [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7, drz, dyx;
    dyx = my - mx;
    drz = c_rho - mz;
    a0 = fmul(dyx, c_dt);
    a1 = fmul(a0, c_sigma);
    a2 = fmul(mx, c_dt);
    a3 = fmul(a2, drz);
    a4 = fmul(my, c_dt);
    a5 = fmul(a2, my);
    a6 = fmul(mz, c_dt);
    a7 = fmul(a6, c_beta);
    mx = mx + a1;
    my = my + a3 - a4;
    mz = mz + a5 - a7;
  endtask

  // Model update on each edge, then compare all outputs just after it
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      md_sv   = 0;
      md_done = 0;
      if (reset) begin
        md_busy = 0;
        md_idx  = 0;
        mx = X0; my = Y0; mz = Z0;
      end else if (!md_busy) begin
        if (reload) begin
          mx = X0; my = Y0; mz = Z0;
        end else if (start) begin
          if (n_steps == '0) begin
            md_done = 1;
          end else begin
            md_busy = 1; md_phase = 0; md_idx = 0; md_n = int'(n_steps);
            c_dt = dt; c_sigma = sigma; c_beta = beta; c_rho = rho;
          end
        end
      end else begin
        md_phase++;
        if (md_phase == 9) begin
          model_step();
          md_idx++;
          md_sv = 1;
          md_phase = 0;
          if (halt) md_busy = 0;
          else if (md_idx == md_n) begin
            md_busy = 0;
            md_done = 1;
          end
        end else if (halt) begin
          md_busy = 0;
        end
      end
      #1;
      vectors++;
      if (busy !== md_busy || step_valid !== md_sv || done !== md_done ||
          step_idx !== CW'(md_idx) || X_K !== mx || Y_K !== my || Z_K !== mz) begin
        miscompares++;
        $display("FAIL cycle %0d (got/exp): busy %0b/%0b sv %0b/%0b done %0b/%0b idx %0d/%0d X %0d/%0d Y %0d/%0d Z %0d/%0d",
                 cyc, busy, md_busy, step_valid, md_sv, done, md_done, step_idx, md_idx,
                 X_K, mx, Y_K, my, Z_K, mz);
      end
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic set_base();
    dt = 27'sd4096; sigma = 27'sd10485760; beta = 27'sd2796202; rho = 27'sd29360128;
    X0 = -27'sd1048576; Y0 = 27'sd104857; Z0 = 27'sd26214400;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic start_run(input int n);
    n_steps = CW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int budget, output int dly, output int nsv);
    bit got;
    got = 0; nsv = 0; dly = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (step_valid) nsv++;
      if (done) begin
        dly = cyc - t0;
        got = 1;
        break;
      end
      if (!busy) break;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: no done pulse within %0d cycles", budget);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dly, nsv;
    set_base();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_idx", step_idx, 0);
    chk("reset_x", X_K, -1048576);

    // Single step
    start_run(1);
    wait_done(40, dly, nsv);
    chk("s1_latency", dly, 9);
    chk("s1_sv_count", nsv, 1);
    chk("s1_x", X_K, -1003526);
    chk("s1_y", Y_K, 92160);
    chk("s1_z", Z_K, 25940924);
    chk("s1_model_x", mx, -1003526);
    chk("s1_model_z", mz, 25940924);
    @(negedge clk);
    chk("s1_busy_after", busy, 0);

    // Three back-to-back steps
    do_reload();
    start_run(3);
    wait_done(60, dly, nsv);
    chk("s3_latency", dly, 27);
    chk("s3_sv_count", nsv, 3);
    chk("s3_idx", step_idx, 3);

    // Zero-step request
    do_reload();
    start_run(0);
    chk("n0_done", done, 1);
    chk("n0_busy", busy, 0);
    chk("n0_x", X_K, -1048576);
    @(negedge clk);
    chk("n0_idx_held", step_idx, 3);

    // Halt mid-run at cycle 13
    start_run(5);
    while (cyc < t0 + 12) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("halt_busy", busy, 0);
    chk("halt_idx", step_idx, 1);
    chk("halt_x", X_K, -1003526);
    chk("halt_y", Y_K, 92160);
    repeat (3) @(negedge clk);

    // Halt landing on the update edge of a non-final step
    do_reload();
    start_run(2);
    while (cyc < t0 + 8) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    chk("halt_upd_sv", step_valid, 1);
    chk("halt_upd_done", done, 0);
    chk("halt_upd_busy", busy, 0);
    chk("halt_upd_z", Z_K, 25940924);

    // Inputs changed while busy are ignored
    do_reload();
    start_run(2);
    while (cyc < t0 + 3) @(negedge clk);
    sigma = 27'sd5242880; X0 = 27'sd777; start = 1'b1; reload = 1'b1;
    @(negedge clk);
    start = 1'b0; reload = 1'b0;
    wait_done(40, dly, nsv);
    chk("ign_latency", dly, 18);
    chk("ign_sv_count", nsv, 2);

    // reload and start together in IDLE: reload only
    X0 = 27'sd12345;
    n_steps = CW'(2);
    start = 1'b1; reload = 1'b1;
    @(negedge clk);
    start = 1'b0; reload = 1'b0;
    chk("rs_busy", busy, 0);
    chk("rs_x", X_K, 12345);
    @(negedge clk);
    chk("rs_busy2", busy, 0);

    // Reset mid-run at cycle 5
    set_base();
    start_run(3);
    while (cyc < t0 + 4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_idx", step_idx, 0);
    chk("rst_x", X_K, -1048576);
    chk("rst_z", Z_K, 26214400);

    // Randomized runs with interfering inputs
    for (int r = 0; r < 30; r++) begin
      dt = W'($urandom_range(8192, 0));
      sigma = rnd(1 << 24); beta = rnd(1 << 23); rho = rnd(1 << 25);
      X0 = rnd(1 << 24); Y0 = rnd(1 << 24); Z0 = rnd(1 << 25);
      do_reload();
      start_run(int'($urandom_range(4, 0)));
      for (int c = 0; c < 60 && busy; c++) begin
        halt   = ($urandom_range(49, 0) == 0);
        start  = ($urandom_range(5, 0) == 0);
        reload = ($urandom_range(5, 0) == 0);
        n_steps = CW'($urandom_range(4, 0));
        if ($urandom_range(3, 0) == 0) sigma = rnd(1 << 24);
        if ($urandom_range(3, 0) == 0) X0 = rnd(1 << 24);
        @(negedge clk);
      end
      halt = 1'b0; start = 1'b0; reload = 1'b0;
      chk("rand_run_ends", busy, 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
